// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg - shared register offsets, STATUS bit positions and the CFG
// field layout for the UART APB register file.
package uart_apb_pkg;

   // Word offsets, which are byte address bits [4:2]
   localparam logic [2:0] REG_TXDATA = 3'd0;  // 0x00
   localparam logic [2:0] REG_RXDATA = 3'd1;  // 0x04
   localparam logic [2:0] REG_CFG    = 3'd2;  // 0x08
   localparam logic [2:0] REG_CTRL   = 3'd3;  // 0x0C
   localparam logic [2:0] REG_STATUS = 3'd4;  // 0x10
   localparam logic [2:0] REG_IER    = 3'd5;  // 0x14

   // STATUS bit positions
   localparam int ST_TXDONE  = 0;
   localparam int ST_RXAVAIL = 1;
   localparam int ST_PERR    = 2;
   localparam int ST_OVR     = 3;
   localparam int ST_TXBUSY  = 4;

   // CFG[4:0] as seen by the UART core
   typedef struct packed {
      logic       parity_type;   // CFG[4]
      logic       parity_en;     // CFG[3]
      logic       stop_bit_num;  // CFG[2]
      logic [1:0] data_bit_num;  // CFG[1:0]
   } cfg_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo - synchronous FIFO for received bytes plus parity flag.
// A push while full is accepted only when a pop happens in the same cycle.
// Only instantiated when UART_RX_FIFO_EN is defined.
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 9
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // NOTE: storage has no reset; the pointers and count define validity,
   // so resetting them is enough and keeps the array a plain RAM.
   // Storage write port
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   // Pointer and occupancy tracking
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/uart_apb_regs.sv
// uart_apb_regs - APB3 slave register file for the UART core.
// Configuration macro UART_RX_FIFO_EN: when defined, received bytes are
// buffered in an RX_DEPTH-entry FIFO; otherwise a single holding register.
module uart_apb_regs
   import uart_apb_pkg::*;
#(
   parameter int         ADDR_W   = 12,
   parameter int         DATA_W   = 32,
   parameter int         RX_DEPTH = 8,
   parameter logic [4:0] CFG_RST  = 5'h03
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   input  logic              tx_done,
   input  logic              rx_done,
   input  logic [7:0]        rx_data,
   input  logic              parity_error,
   output logic [7:0]        tx_data,
   output logic [1:0]        data_bit_num,
   output logic              stop_bit_num,
   output logic              parity_en,
   output logic              parity_type,
   output logic              start_tx,
   output logic              irq
);

   logic              setup_ph;
   logic              access_ph;
   logic [2:0]        reg_off;
   logic              addr_err;
   logic              wr_en;
   logic              start_go;
   logic              clr_txdone;
   logic              clr_perr;
   logic              clr_ovr;
   logic              pop_pend;
   logic              rx_pop;
   logic              ovr_set;

   logic [7:0]        txdata_q;
   cfg_t              cfg_q;
   logic [3:0]        ier_q;
   logic              tx_busy;
   logic              txdone_st;
   logic              perr_st;
   logic              ovr_st;

   logic [8:0]        rx_head;
   logic              rx_full;
   logic              rx_empty;
   logic [8:0]        rx_cnt9;
   logic [7:0]        rx_cnt8;
   logic [15:0]       status_w;
   logic [DATA_W-1:0] rd_mux;
   logic              unused_bits;

   assign setup_ph  = psel & ~penable;
   assign access_ph = psel & penable;
   assign reg_off   = paddr[4:2];

   // Misaligned, out-of-window, write to RXDATA, or read of CTRL
   assign addr_err = (paddr[1:0] != 2'b00)
                   | (paddr[ADDR_W-1:5] != '0)
                   | (reg_off > REG_IER)
                   | (pwrite  && (reg_off == REG_RXDATA))
                   | (!pwrite && (reg_off == REG_CTRL));

   assign wr_en      = access_ph & pwrite & ~addr_err;
   assign start_go   = wr_en && (reg_off == REG_CTRL) && pwdata[0] && !tx_busy;
   assign clr_txdone = wr_en && (reg_off == REG_STATUS) && pwdata[ST_TXDONE];
   assign clr_perr   = wr_en && (reg_off == REG_STATUS) && pwdata[ST_PERR];
   assign clr_ovr    = wr_en && (reg_off == REG_STATUS) && pwdata[ST_OVR];

   // Pop only if the SETUP sample actually returned a byte
   assign rx_pop  = access_ph & pop_pend;
   assign ovr_set = rx_done & rx_full & ~rx_pop;

`ifdef UART_RX_FIFO_EN
   logic [$clog2(RX_DEPTH):0] fifo_count;

   uart_rx_fifo #(
      .DEPTH (RX_DEPTH),
      .W     (9)
   ) u_rx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (rx_done),
      .pop     (rx_pop),
      .din     ({parity_error, rx_data}),
      .dout    (rx_head),
      .full    (rx_full),
      .empty   (rx_empty),
      .count   (fifo_count)
   );

   assign rx_cnt9 = 9'(fifo_count);
`else
   logic       hold_valid;
   logic [8:0] hold_data;

   // Single-entry holding register; a byte is accepted if empty or popped now
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (rx_done && (!hold_valid || rx_pop)) begin
         hold_valid <= 1'b1;
         hold_data  <= {parity_error, rx_data};
      end else if (rx_pop) begin
         hold_valid <= 1'b0;
      end
   end

   assign rx_head  = hold_data;
   assign rx_full  = hold_valid;
   assign rx_empty = ~hold_valid;
   assign rx_cnt9  = {8'd0, hold_valid};
`endif

   // Count field is 8 bits wide; a 256-deep FIFO saturates at 255
   assign rx_cnt8 = rx_cnt9[8] ? 8'hFF : rx_cnt9[7:0];

   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned, which would infer a latch.
   // STATUS view assembled from sticky bits and live FIFO/TX state
   always_comb begin
      status_w             = '0;
      status_w[ST_TXDONE]  = txdone_st;
      status_w[ST_RXAVAIL] = ~rx_empty;
      status_w[ST_PERR]    = perr_st;
      status_w[ST_OVR]     = ovr_st;
      status_w[ST_TXBUSY]  = tx_busy;
      status_w[15:8]       = rx_cnt8;
   end

   // Read-data mux; unused bits and empty RXDATA read as zero
   always_comb begin
      rd_mux = '0;
      case (reg_off)
         REG_TXDATA: rd_mux[7:0]  = txdata_q;
         REG_RXDATA: if (!rx_empty) rd_mux[7:0] = rx_head[7:0];
         REG_CFG:    rd_mux[4:0]  = cfg_q;
         REG_STATUS: rd_mux[15:0] = status_w;
         REG_IER:    rd_mux[3:0]  = ier_q;
         default:    rd_mux = '0;
      endcase
   end

   // APB response: data and error captured in SETUP, held through ACCESS
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prdata   <= '0;
         pslverr  <= 1'b0;
         pop_pend <= 1'b0;
      end else if (setup_ph) begin
         prdata   <= (addr_err || pwrite) ? '0 : rd_mux;
         pslverr  <= addr_err;
         pop_pend <= !pwrite && !addr_err && (reg_off == REG_RXDATA) && !rx_empty;
      end else begin
         pslverr  <= 1'b0;
         pop_pend <= 1'b0;
      end
   end

   // Writable registers, sticky status (set beats W1C), start pulse and irq
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         txdata_q  <= '0;
         cfg_q     <= cfg_t'(CFG_RST);
         ier_q     <= '0;
         tx_busy   <= 1'b0;
         txdone_st <= 1'b0;
         perr_st   <= 1'b0;
         ovr_st    <= 1'b0;
         start_tx  <= 1'b0;
         irq       <= 1'b0;
      end else begin
         if (wr_en && (reg_off == REG_TXDATA)) txdata_q <= pwdata[7:0];
         if (wr_en && (reg_off == REG_CFG))    cfg_q    <= cfg_t'(pwdata[4:0]);
         if (wr_en && (reg_off == REG_IER))    ier_q    <= pwdata[3:0];

         if (start_go)     tx_busy <= 1'b1;
         else if (tx_done) tx_busy <= 1'b0;

         txdone_st <= tx_done | (txdone_st & ~clr_txdone);
         perr_st   <= (rx_done & parity_error) | (perr_st & ~clr_perr);
         ovr_st    <= ovr_set | (ovr_st & ~clr_ovr);
         start_tx  <= start_go;
         irq       <= |(status_w[3:0] & ier_q);
      end
   end

   assign pready       = 1'b1;
   assign tx_data      = txdata_q;
   assign data_bit_num = cfg_q.data_bit_num;
   assign stop_bit_num = cfg_q.stop_bit_num;
   assign parity_en    = cfg_q.parity_en;
   assign parity_type  = cfg_q.parity_type;

   // Write-data bits beyond the widest register and the stored parity flag
   assign unused_bits = ^{pwdata[DATA_W-1:8], rx_head[8]};

endmodule
